// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - latches key press edges and serializes them through a round-robin arbiter
// into a single registered valid/ready event slot.
module key_event_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_in,
  input  logic [WIDTH-1:0] key_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic [WIDTH-1:0] pending,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic [WIDTH-1:0] key_prev_q, key_prev_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] clr;
  logic             load;
  logic             found;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W:0]   pos;

  // The first cycle after reset only captures levels, so keys held through reset stay silent.
  always_comb begin
    rise = '0;
    if (primed_q) rise = key_in & ~key_prev_q & key_en;
  end

  // Rotating search starting one past the last winner; the wide sum covers non-power-of-two WIDTH.
  always_comb begin
    cand    = pend_q & key_en;
    found   = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(WIDTH)) pos = pos - (IDX_W+1)'(WIDTH);
      if (!found && cand[pos[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = pos[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    load        = ~evt_valid_q | evt_ready;
    clr         = '0;
    evt_valid_d = evt_valid_q;
    evt_idx_d   = evt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (found) begin
        evt_valid_d  = 1'b1;
        evt_idx_d    = gnt_idx;
        rr_ptr_d     = gnt_idx;
        clr[gnt_idx] = 1'b1;
      end else begin
        evt_valid_d = 1'b0;
      end
    end
  end

  // A new press wins over the grant clear; a press onto a still-pending key is counted as lost.
  always_comb begin
    key_prev_d = key_in;
    primed_d   = 1'b1;
    pend_d     = ((pend_q & ~clr) | rise) & key_en;
    ovf_d      = (ovf_q & ~ovf_clr) | (|(rise & pend_q & ~clr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev_q  <= '0;
      primed_q    <= 1'b0;
      pend_q      <= '0;
      rr_ptr_q    <= IDX_W'(WIDTH-1);
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      key_prev_q  <= key_prev_d;
      primed_q    <= primed_d;
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_idx_q   <= evt_idx_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_idx   = evt_idx_q;
  assign pending   = pend_q;
  assign ovf       = ovf_q;

endmodule
